// File: rtl/fifo_core.sv
// fifo_core: single-clock synchronous FIFO, DATA_WIDTH x DEPTH.
//
// The read port is registered. data_out updates one cycle after a read is
// accepted and holds its value otherwise. The full/empty/half flags are
// registered and derived from the next-state occupancy count.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, the overflow and underflow ports are present. Each is a
//   one-cycle pulse that marks a dropped write or a read issued while empty.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst_n      in   synchronous reset, active low
//   wr_en      in   write request
//   rd_en      in   read request
//   data_in    in   [DATA_WIDTH] write data
//   data_out   out  [DATA_WIDTH] registered read data
//   full       out  count == DEPTH
//   empty      out  count == 0
//   half       out  count >= DEPTH/2
//   overflow   out  (FIFO_ERR_FLAGS_EN) write dropped on the previous edge
//   underflow  out  (FIFO_ERR_FLAGS_EN) read requested while empty on the previous edge
module fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  half,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  half
`endif
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CW         = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH / 2);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  full_q, empty_q, half_q;
  logic                  wr_acc, rd_acc;

  // When the FIFO is full, a write can still be accepted if a read frees a
  // slot on the same edge.
  assign rd_acc = rd_en & ~empty_q;
  assign wr_acc = wr_en & (~full_q | rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      half_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      half_q     <= (count_d >= CNT_HALF);
    end
  end

  // Storage is not reset. Writes are blocked while reset is asserted so that
  // reset discards every in-flight access.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = data_out_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign half     = half_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en & ~wr_acc;
      underflow_q <= rd_en & empty_q;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_core.sv
module tb_fifo_core;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, half;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  fifo_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
`ifdef FIFO_ERR_FLAGS_EN
    .half     (half),
    .overflow (overflow),
    .underflow(underflow)
`else
    .half     (half)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mdl[$];   // reference contents of the FIFO
  logic [DW-1:0] sb[$];    // expected read data, in order
  logic [DW-1:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    int n = mdl.size();
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".half"},  32'(half),  32'(n >= DEPTH / 2));
  endtask

  // One clock: drive at posedge+1, check at the next posedge+1.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit mfull  = (mdl.size() == DEPTH);
    bit mempty = (mdl.size() == 0);
    bit racc   = r && !mempty;
    bit wacc   = w && (!mfull || racc);
    if (racc) sb.push_back(mdl.pop_front());
    if (wacc) mdl.push_back(d);
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (racc) begin
      last_exp = sb.pop_front();
      check({tag, ".rd_data"}, 32'(data_out), 32'(last_exp));
    end else begin
      check({tag, ".hold"}, 32'(data_out), 32'(last_exp));
    end
    check_flags(tag);
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},  32'(overflow),  32'(w && !wacc));
    check({tag, ".underflow"}, 32'(underflow), 32'(r && mempty));
`endif
  endtask

  task automatic do_reset(input logic w, input logic [DW-1:0] d);
    rst_n = 1'b0; wr_en = w; rd_en = 1'b0; data_in = d;
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0;
    mdl.delete(); sb.delete(); last_exp = '0;
    check("reset.data_out", 32'(data_out), 32'h0);
    check_flags("reset");
`ifdef FIFO_ERR_FLAGS_EN
    check("reset.overflow",  32'(overflow),  32'h0);
    check("reset.underflow", 32'(underflow), 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0, '0);

    // Half-fill, then drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'h11 + i), "half_wr");
    check("half_after_8", 32'(half), 32'h1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "half_rd");
    check("empty_after_drain", 32'(empty), 32'h1);

    // Fill, drop a write while full, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h20 + 3 * i), "fill_wr");
    check("full_after_16", 32'(full), 32'h1);
    step(1'b1, 1'b0, 8'hAA, "drop_wr");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "fill_rd");

    // Simultaneous write and read while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h40 + i), "full2_wr");
    step(1'b1, 1'b1, 8'h5C, "full_rw");
    check("full_rw.still_full", 32'(full), 32'h1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "full2_rd");
    check("last_is_5c", 32'(data_out), 32'h5C);

    // Read while empty, then simultaneous write and read while empty
    step(1'b0, 1'b1, '0, "empty_rd");
    step(1'b1, 1'b1, 8'h3D, "empty_rw");
    check("empty_rw.not_empty", 32'(empty), 32'h0);
    step(1'b0, 1'b1, '0, "read_3d");
    check("got_3d", 32'(data_out), 32'h3D);

    // Pointer wrap, then reset mid-stream
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(8'h60 + i), "wrap_wr");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, "wrap_rd");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h80 + i), "wrap_fill");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, "wrap_part");
    do_reset(1'b1, 8'hEE);
    step(1'b1, 1'b0, 8'h77, "post_rst_wr");
    step(1'b0, 1'b1, '0, "post_rst_rd");
    check("post_rst_data", 32'(data_out), 32'h77);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
